kf6845_memory_address: RTL and testbench

Refresh memory address and cursor generator for the KF6845 CRTC. Sits downstream of the vertical and horizontal control stages. Consumes their frame, row and line timing strobes and produces the 14-bit refresh address MA, the combined display enable DISPEN, and the CURSOR output. Also owns CRTC registers R10–R15 (cursor start/end, start address, cursor address).

---
 rtl/kf6845_pkg.sv | 28 ++
 rtl/kf6845_cursor_control.sv | 74 +++++++
 rtl/kf6845_memory_address.sv | 98 +++++++++
 tb/tb_kf6845_memory_address.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf6845_pkg.sv
// Shared types and constants for the KF6845 refresh address and cursor path.
// Pure declarations: no latency, no backpressure.
package kf6845_pkg;

    localparam int MA_WIDTH = 14;

    typedef logic [MA_WIDTH-1:0] ma_t;

    localparam logic [1:0] BLINK_STEADY = 2'b00;
    localparam logic [1:0] BLINK_OFF    = 2'b01;
    localparam logic [1:0] BLINK_16     = 2'b10;
    localparam logic [1:0] BLINK_32     = 2'b11;

    // Blink phases are "on" while the selected field_count bit is low.
    function automatic logic blink_gate(input logic [1:0] mode, input logic [4:0] field_count);
        logic on;
        on = 1'b1;
        case (mode)
            BLINK_STEADY: on = 1'b1;
            BLINK_OFF:    on = 1'b0;
            BLINK_16:     on = ~field_count[3];
            BLINK_32:     on = ~field_count[4];
            default:      on = 1'b1;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/kf6845_cursor_control.sv
// Cursor registers R10/R11/R14/R15, field counter, blink gate and MA compare.
// CURSOR registered on each character clock enable (1 char of lag); no backpressure.
module kf6845_cursor_control
    import kf6845_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       vce_i,
    input  logic [7:0] data_i,
    input  logic       wr_r10_i,
    input  logic       wr_r11_i,
    input  logic       wr_r14_i,
    input  logic       wr_r15_i,
    input  logic       v_total_i,
    input  logic       display_i,
    input  ma_t        ma_i,
    input  logic [4:0] ra_i,
    output logic       cursor_o
);

    logic [4:0] cursor_start_q, cursor_start_d;
    logic [1:0] blink_mode_q,   blink_mode_d;
    logic [4:0] cursor_end_q,   cursor_end_d;
    ma_t        cursor_addr_q,  cursor_addr_d;
    logic [4:0] field_count_q,  field_count_d;
    logic       cursor_q,       cursor_d;
    logic       hit;

    // An inverted start/end window makes the raster test unsatisfiable, hiding the cursor.
    assign hit = display_i
               & (ma_i == cursor_addr_q)
               & (ra_i >= cursor_start_q)
               & (ra_i <= cursor_end_q)
               & blink_gate(blink_mode_q, field_count_q);

    always_comb begin
        cursor_start_d = cursor_start_q;
        blink_mode_d   = blink_mode_q;
        cursor_end_d   = cursor_end_q;
        cursor_addr_d  = cursor_addr_q;
        field_count_d  = field_count_q;
        cursor_d       = cursor_q;
        if (wr_r10_i) begin
            cursor_start_d = data_i[4:0];
            blink_mode_d   = data_i[6:5];
        end
        if (wr_r11_i) cursor_end_d = data_i[4:0];
        if (wr_r14_i) cursor_addr_d[13:8] = data_i[5:0];
        if (wr_r15_i) cursor_addr_d[7:0] = data_i;
        if (v_total_i) field_count_d = field_count_q + 5'd1;
        if (vce_i) cursor_d = hit;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cursor_start_q <= '0;
            blink_mode_q   <= '0;
            cursor_end_q   <= '0;
            cursor_addr_q  <= '0;
            field_count_q  <= '0;
            cursor_q       <= 1'b0;
        end else begin
            cursor_start_q <= cursor_start_d;
            blink_mode_q   <= blink_mode_d;
            cursor_end_q   <= cursor_end_d;
            cursor_addr_q  <= cursor_addr_d;
            field_count_q  <= field_count_d;
            cursor_q       <= cursor_d;
        end
    end

    assign cursor_o = cursor_q;

endmodule

// File: rtl/kf6845_memory_address.sv
// KF6845 refresh address (MA), DISPEN and CURSOR generator; MA moves 1 clock after its strobe,
// DISPEN/CURSOR lag MA by one character. No backpressure. Cursor logic gated by KF6845_CURSOR_EN.
module kf6845_memory_address
    import kf6845_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                video_clock_enable,
    input  logic [7:0]          internal_data_bus,
    input  logic                write_cursor_start_register,
    input  logic                write_cursor_end_register,
    input  logic                write_start_address_h_register,
    input  logic                write_start_address_l_register,
    input  logic                write_cursor_h_register,
    input  logic                write_cursor_l_register,
    input  logic [7:0]          horizontal_displayed,
    input  logic                Horizontal,
    input  logic                H_Display,
    input  logic                V_Display,
    input  logic                V_Total,
    input  logic                Scanline_End,
    input  logic [4:0]          RA,
    output logic [MA_WIDTH-1:0] MA,
    output logic                DISPEN,
    output logic                CURSOR
);

    ma_t  start_addr_q, start_addr_d;
    ma_t  row_start_q,  row_start_d;
    ma_t  ma_q,         ma_d;
    logic dispen_q,     dispen_d;
    logic line_end;

    assign line_end = video_clock_enable & Horizontal;

    always_comb begin
        start_addr_d = start_addr_q;
        row_start_d  = row_start_q;
        ma_d         = ma_q;
        dispen_d     = dispen_q;
        if (write_start_address_h_register) start_addr_d[13:8] = internal_data_bus[5:0];
        if (write_start_address_l_register) start_addr_d[7:0] = internal_data_bus;
        // Start address is only sampled at frame end, so mid-frame writes never disturb MA.
        if (V_Total) begin
            ma_d        = start_addr_q;
            row_start_d = start_addr_q;
        end else if (line_end & Scanline_End) begin
            row_start_d = row_start_q + ma_t'(horizontal_displayed);
            ma_d        = row_start_q + ma_t'(horizontal_displayed);
        end else if (line_end) begin
            ma_d = row_start_q;
        end else if (video_clock_enable) begin
            ma_d = ma_q + ma_t'(1);
        end
        if (video_clock_enable) dispen_d = H_Display & V_Display;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_addr_q <= '0;
            row_start_q  <= '0;
            ma_q         <= '0;
            dispen_q     <= 1'b0;
        end else begin
            start_addr_q <= start_addr_d;
            row_start_q  <= row_start_d;
            ma_q         <= ma_d;
            dispen_q     <= dispen_d;
        end
    end

    assign MA     = ma_q;
    assign DISPEN = dispen_q;

`ifdef KF6845_CURSOR_EN
    kf6845_cursor_control u_cursor (
        .clock_i   (clock),
        .reset_i   (reset),
        .vce_i     (video_clock_enable),
        .data_i    (internal_data_bus),
        .wr_r10_i  (write_cursor_start_register),
        .wr_r11_i  (write_cursor_end_register),
        .wr_r14_i  (write_cursor_h_register),
        .wr_r15_i  (write_cursor_l_register),
        .v_total_i (V_Total),
        .display_i (H_Display & V_Display),
        .ma_i      (ma_q),
        .ra_i      (RA),
        .cursor_o  (CURSOR)
    );
`else
    logic unused_cursor_inputs;
    assign unused_cursor_inputs = ^{write_cursor_start_register, write_cursor_end_register,
                                    write_cursor_h_register, write_cursor_l_register, RA};
    assign CURSOR = 1'b0;
`endif

endmodule

// File: tb/tb_kf6845_memory_address.sv
// Randomized and directed bench for kf6845_memory_address against a behavioural model.
// Cursor expectations follow KF6845_CURSOR_EN.
module tb_kf6845_memory_address;

`ifdef KF6845_CURSOR_EN
    localparam bit CURSOR_EN = 1'b1;
`else
    localparam bit CURSOR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        video_clock_enable;
    logic [7:0]  internal_data_bus;
    logic        write_cursor_start_register;
    logic        write_cursor_end_register;
    logic        write_start_address_h_register;
    logic        write_start_address_l_register;
    logic        write_cursor_h_register;
    logic        write_cursor_l_register;
    logic [7:0]  horizontal_displayed;
    logic        Horizontal;
    logic        H_Display;
    logic        V_Display;
    logic        V_Total;
    logic        Scanline_End;
    logic [4:0]  RA;
    logic [13:0] MA;
    logic        DISPEN;
    logic        CURSOR;

    always #5 clock = ~clock;

    kf6845_memory_address dut (
        .clock                          (clock),
        .reset                          (reset),
        .video_clock_enable             (video_clock_enable),
        .internal_data_bus              (internal_data_bus),
        .write_cursor_start_register    (write_cursor_start_register),
        .write_cursor_end_register      (write_cursor_end_register),
        .write_start_address_h_register (write_start_address_h_register),
        .write_start_address_l_register (write_start_address_l_register),
        .write_cursor_h_register        (write_cursor_h_register),
        .write_cursor_l_register        (write_cursor_l_register),
        .horizontal_displayed           (horizontal_displayed),
        .Horizontal                     (Horizontal),
        .H_Display                      (H_Display),
        .V_Display                      (V_Display),
        .V_Total                        (V_Total),
        .Scanline_End                   (Scanline_End),
        .RA                             (RA),
        .MA                             (MA),
        .DISPEN                         (DISPEN),
        .CURSOR                         (CURSOR)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: registers held as plain integers.
    int m_ma, m_row, m_start, m_cur_addr, m_cs, m_ce, m_mode, m_fc;
    bit m_dispen, m_cursor;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit blink_on(input int mode, input int fc);
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return ((fc / 8) % 2) == 0;
            default: return ((fc / 16) % 2) == 0;
        endcase
    endfunction

    task automatic model_update();
        int n_ma, n_row;
        bit vis;
        if (reset) begin
            m_ma = 0; m_row = 0; m_start = 0; m_cur_addr = 0;
            m_cs = 0; m_ce = 0; m_mode = 0; m_fc = 0;
            m_dispen = 0; m_cursor = 0;
            return;
        end
        n_ma = m_ma;
        n_row = m_row;
        if (V_Total) begin
            n_ma = m_start; n_row = m_start;
        end else if (video_clock_enable && Horizontal && Scanline_End) begin
            n_row = (m_row + int'(horizontal_displayed)) % 16384;
            n_ma = n_row;
        end else if (video_clock_enable && Horizontal) begin
            n_ma = m_row;
        end else if (video_clock_enable) begin
            n_ma = (m_ma + 1) % 16384;
        end
        if (video_clock_enable) begin
            vis = CURSOR_EN && H_Display && V_Display && (m_ma == m_cur_addr)
                  && (int'(RA) >= m_cs) && (int'(RA) <= m_ce) && blink_on(m_mode, m_fc);
            m_dispen = H_Display && V_Display;
            m_cursor = vis;
        end
        if (V_Total) m_fc = (m_fc + 1) % 32;
        if (write_start_address_h_register) m_start = (int'(internal_data_bus) % 64) * 256 + (m_start % 256);
        if (write_start_address_l_register) m_start = (m_start / 256) * 256 + int'(internal_data_bus);
        if (write_cursor_start_register) begin
            m_cs = int'(internal_data_bus) % 32;
            m_mode = (int'(internal_data_bus) / 32) % 4;
        end
        if (write_cursor_end_register) m_ce = int'(internal_data_bus) % 32;
        if (write_cursor_h_register) m_cur_addr = (int'(internal_data_bus) % 64) * 256 + (m_cur_addr % 256);
        if (write_cursor_l_register) m_cur_addr = (m_cur_addr / 256) * 256 + int'(internal_data_bus);
        m_ma = n_ma;
        m_row = n_row;
    endtask

    // One clock: model follows the inputs held across the edge, outputs are compared 1ns later.
    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
        check_eq("MA", 32'(MA), m_ma);
        check_eq("DISPEN", 32'(DISPEN), 32'(m_dispen));
        check_eq("CURSOR", 32'(CURSOR), 32'(m_cursor));
    endtask

    task automatic idle_inputs();
        video_clock_enable = 0; internal_data_bus = 0;
        write_cursor_start_register = 0; write_cursor_end_register = 0;
        write_start_address_h_register = 0; write_start_address_l_register = 0;
        write_cursor_h_register = 0; write_cursor_l_register = 0;
        Horizontal = 0; V_Total = 0; Scanline_End = 0;
    endtask

    task automatic write_reg(input int r, input logic [7:0] d);
        internal_data_bus = d;
        write_cursor_start_register    = (r == 10);
        write_cursor_end_register      = (r == 11);
        write_start_address_h_register = (r == 12);
        write_start_address_l_register = (r == 13);
        write_cursor_h_register        = (r == 14);
        write_cursor_l_register        = (r == 15);
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic pulse_vtotal();
        V_Total = 1; tick(); V_Total = 0;
    endtask

    task automatic run_enables(input int n, output int cursor_cnt);
        cursor_cnt = 0;
        video_clock_enable = 1;
        for (int i = 0; i < n; i++) begin
            tick();
            cursor_cnt += int'(CURSOR);
        end
        video_clock_enable = 0;
    endtask

    task automatic setup_cursor(input logic [7:0] r10);
        write_reg(12, 8'h01); write_reg(13, 8'h00);
        write_reg(10, r10);   write_reg(11, 8'h07);
        write_reg(14, 8'h01); write_reg(15, 8'h05);
    endtask

    initial begin
        int cnt;
        int exp_cnt;
        idle_inputs();
        reset = 1; H_Display = 0; V_Display = 0; RA = 0; horizontal_displayed = 8'd80;

        tick(); tick();
        check_eq("reset_ma", 32'(MA), 0);
        check_eq("reset_dispen", 32'(DISPEN), 0);
        check_eq("reset_cursor", 32'(CURSOR), 0);
        reset = 0;

        // Start address load, line repeat, row advance
        write_reg(12, 8'h01); write_reg(13, 8'h00);
        pulse_vtotal();
        check_eq("sa_load", 32'(MA), 32'h0100);
        run_enables(80, cnt);
        check_eq("ma_after_80", 32'(MA), 32'h0150);
        video_clock_enable = 1; Horizontal = 1; tick(); idle_inputs();
        check_eq("line_repeat", 32'(MA), 32'h0100);
        video_clock_enable = 1; Horizontal = 1; Scanline_End = 1; tick(); idle_inputs();
        check_eq("row_advance", 32'(MA), 32'h0150);
        run_enables(5, cnt);
        check_eq("row_count", 32'(MA), 32'h0155);
        video_clock_enable = 1; Horizontal = 1; tick(); idle_inputs();
        check_eq("row_start_kept", 32'(MA), 32'h0150);
        V_Total = 1; video_clock_enable = 1; Horizontal = 1; Scanline_End = 1; tick(); idle_inputs();
        check_eq("vtotal_wins", 32'(MA), 32'h0100);
        write_reg(12, 8'h02);
        run_enables(3, cnt);
        check_eq("sa_write_midframe", 32'(MA), 32'h0103);

        // Wrap-around
        write_reg(12, 8'h3F); write_reg(13, 8'hFE);
        pulse_vtotal();
        run_enables(4, cnt);
        check_eq("wrap", 32'(MA), 32'h0002);

        // Cursor raster window
        do_reset();
        setup_cursor(8'h06);
        H_Display = 1; V_Display = 1;
        for (int ra = 0; ra < 9; ra++) begin
            RA = 5'(ra);
            pulse_vtotal();
            run_enables(7, cnt);
            exp_cnt = (CURSOR_EN && (ra == 6 || ra == 7)) ? 1 : 0;
            check_eq($sformatf("cursor_ra%0d", ra), 32'(cnt), 32'(exp_cnt));
        end
        write_reg(10, 8'h08);
        RA = 5'd7; pulse_vtotal(); run_enables(7, cnt);
        check_eq("cursor_inverted", 32'(cnt), 0);

        // Blink 8/8, then always off
        do_reset();
        setup_cursor(8'h46);
        RA = 5'd6;
        for (int k = 1; k <= 24; k++) begin
            pulse_vtotal();
            run_enables(7, cnt);
            exp_cnt = (CURSOR_EN && ((k / 8) % 2 == 0)) ? 1 : 0;
            check_eq($sformatf("blink_f%0d", k), 32'(cnt), 32'(exp_cnt));
        end
        write_reg(10, 8'h26);
        for (int k = 0; k < 4; k++) begin
            pulse_vtotal();
            run_enables(7, cnt);
            check_eq("blink_off", 32'(cnt), 0);
        end

        // Reset mid-frame
        pulse_vtotal();
        run_enables(6, cnt);
        video_clock_enable = 1; reset = 1; tick(); reset = 0; video_clock_enable = 0;
        check_eq("midrst_ma", 32'(MA), 0);
        check_eq("midrst_dispen", 32'(DISPEN), 0);
        check_eq("midrst_cursor", 32'(CURSOR), 0);
        write_reg(12, 8'h01); write_reg(13, 8'h23);
        pulse_vtotal();
        check_eq("midrst_reload", 32'(MA), 32'h0123);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            reset              = ($urandom_range(0, 399) == 0);
            video_clock_enable = ($urandom_range(0, 9) < 7);
            Horizontal         = ($urandom_range(0, 9) == 0);
            Scanline_End       = ($urandom_range(0, 2) == 0);
            V_Total            = ($urandom_range(0, 99) == 0);
            H_Display          = ($urandom_range(0, 4) != 0);
            V_Display          = ($urandom_range(0, 4) != 0);
            RA                 = 5'($urandom_range(3, 10));
            if ($urandom_range(0, 49) == 0) horizontal_displayed = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) begin
                internal_data_bus = 8'($urandom_range(0, 255));
                case ($urandom_range(10, 15))
                    10: write_cursor_start_register = 1;
                    11: write_cursor_end_register = 1;
                    12: write_start_address_h_register = 1;
                    13: write_start_address_l_register = 1;
                    14: write_cursor_h_register = 1;
                    default: begin
                        write_cursor_l_register = 1;
                        internal_data_bus = 8'(m_ma % 256 + $urandom_range(0, 3));
                    end
                endcase
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
